// File: rtl/mac_stream_checker.sv
`timescale 1ns/1ps
// Streaming MAC frame checker: walks each MII frame byte by byte from START to TERM with CRC-32.
// Latency: the done pulse and error flags register on the edge that accepts the closing word.
// Backpressure: none; i_valid low freezes all state, and the block never stalls its source.
//
// Ports: clk / i_rst_n (async, active-low); i_rx_data / i_rx_ctrl / i_valid carry the MII word,
//   where lane 0 is bits [7:0] and is first on the wire. o_frame_done pulses once per closed
//   frame. o_*_error give the status of the last closed frame. o_frame_count and o_error_count
//   count closed frames and closed frames with errors.
// Build option: MAC_CHECKER_STATS_EN builds the two counters; without it both counters read 0.
module mac_stream_checker #(
   parameter int          DATA_WIDTH     = 64,
   parameter int          CTRL_WIDTH     = DATA_WIDTH / 8,
   parameter logic [47:0] DST_ADDR       = 48'hFFFFFFFFFFFF,
   parameter logic [47:0] SRC_ADDR       = 48'h123456789ABC,
   parameter int          MIN_FRAME_SIZE = 64,
   parameter int          MAX_FRAME_SIZE = 1518
) (
   input  logic                  clk,
   input  logic                  i_rst_n,
   input  logic [DATA_WIDTH-1:0] i_rx_data,
   input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
   input  logic                  i_valid,
   output logic                  o_frame_done,
   output logic                  o_preamble_error,
   output logic                  o_header_error,
   output logic                  o_payload_error,
   output logic                  o_fcs_error,
   output logic                  o_length_error,
   output logic [31:0]           o_frame_count,
   output logic [31:0]           o_error_count
);

   localparam logic [7:0]  C_START = 8'hFB;
   localparam logic [7:0]  C_TERM  = 8'hFD;
   localparam logic [7:0]  C_IDLE  = 8'h07;
   localparam logic [15:0] MIN_L   = 16'(MIN_FRAME_SIZE);
   localparam logic [15:0] MAX_L   = 16'(MAX_FRAME_SIZE);
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_BODY, S_DRAIN} state_t;

   state_t      r_state;
   logic [4:0]  r_pos;        // position of the next byte; START is position 0
   logic [15:0] r_len;        // DA..FCS byte count, saturating
   logic [31:0] r_crc;
   logic [15:0] r_len_type;
   logic        r_pre_err, r_hdr_err, r_len_err;
   logic        r_done, r_pre_o, r_hdr_o, r_pay_o, r_fcs_o, r_len_o;

   state_t      w_state;
   logic [4:0]  w_pos;
   logic [15:0] w_len;
   logic [31:0] w_crc;
   logic [15:0] w_len_type;
   logic        w_pre_err, w_hdr_err, w_len_err;
   logic        w_close;
   logic        w_len_bad, w_pay_bad, w_fcs_bad, w_any_err;
   logic [15:0] w_pay_cnt, w_pay_need;

   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] x;
      x = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
      return x;
   endfunction

   // Lane-serial walk: each lane sees the state left by the previous lane, so a word behaves
   // exactly like CTRL_WIDTH consecutive byte cycles.
   always_comb begin
      logic [7:0] w_byte;
      logic       w_ctl;
      logic [7:0] w_hdr_exp;
      logic       w_hdr_chk;
      w_state    = r_state;
      w_pos      = r_pos;
      w_len      = r_len;
      w_crc      = r_crc;
      w_len_type = r_len_type;
      w_pre_err  = r_pre_err;
      w_hdr_err  = r_hdr_err;
      w_len_err  = r_len_err;
      w_close    = 1'b0;
      w_byte     = 8'h00;
      w_ctl      = 1'b0;
      w_hdr_exp  = 8'h00;
      w_hdr_chk  = 1'b0;
      for (int b = 0; b < CTRL_WIDTH; b++) begin
         w_byte = i_rx_data[8*b +: 8];
         w_ctl  = i_rx_ctrl[b];
         // Once the frame closes, the rest of the word is ignored.
         if (!w_close) begin
            case (w_state)
               S_IDLE: begin
                  if (b == 0 && w_ctl && w_byte == C_START) begin
                     w_state    = S_PRE;
                     w_pos      = 5'd1;
                     w_len      = 16'h0000;
                     w_crc      = 32'hFFFFFFFF;
                     w_len_type = 16'h0000;
                     w_pre_err  = 1'b0;
                     w_hdr_err  = 1'b0;
                     w_len_err  = 1'b0;
                  end
               end
               S_PRE: begin
                  if (w_ctl || w_byte != ((w_pos == 5'd7) ? 8'hD5 : 8'h55))
                     w_pre_err = 1'b1;
                  if (w_pos == 5'd7)
                     w_state = S_BODY;
                  w_pos = w_pos + 5'd1;
               end
               S_BODY: begin
                  if (w_ctl) begin
                     if (w_byte == C_TERM) begin
                        w_close = 1'b1;
                     end else begin
                        w_state   = S_DRAIN;
                        w_len_err = 1'b1;
                     end
                  end else begin
                     w_hdr_chk = 1'b0;
                     w_hdr_exp = 8'h00;
                     for (int k = 0; k < 6; k++) begin
                        if (w_pos == 5'(8 + k)) begin
                           w_hdr_exp = DST_ADDR[8*(5-k) +: 8];
                           w_hdr_chk = 1'b1;
                        end
                        if (w_pos == 5'(14 + k)) begin
                           w_hdr_exp = SRC_ADDR[8*(5-k) +: 8];
                           w_hdr_chk = 1'b1;
                        end
                     end
                     if (w_hdr_chk && w_byte != w_hdr_exp)
                        w_hdr_err = 1'b1;
                     if (w_pos == 5'd20) w_len_type[15:8] = w_byte;
                     if (w_pos == 5'd21) w_len_type[7:0]  = w_byte;
                     w_crc = crc32_byte(w_crc, w_byte);
                     if (w_len != 16'hFFFF) w_len = w_len + 16'd1;
                     // Position only matters up to the length/type field; hold it once past.
                     if (w_pos != 5'h1F) w_pos = w_pos + 5'd1;
                  end
               end
               S_DRAIN: begin
                  if (w_ctl && (w_byte == C_TERM || w_byte == C_IDLE))
                     w_close = 1'b1;
               end
               default: w_state = S_IDLE;
            endcase
         end
      end
      if (w_close)
         w_state = S_IDLE;

      // Close evaluation uses the values as they stand at the closing byte.
      w_len_bad  = w_len_err || (w_len < MIN_L) || (w_len > MAX_L);
      w_pay_cnt  = w_len - 16'd18;
      w_pay_need = (w_len_type < 16'd46) ? 16'd46 : w_len_type;
      w_pay_bad  = (w_len >= 16'd18) && (w_len_type <= 16'd1500) && (w_pay_cnt != w_pay_need);
      w_fcs_bad  = (w_crc != CRC_RESIDUE);
      w_any_err  = w_pre_err || w_hdr_err || w_pay_bad || w_fcs_bad || w_len_bad;
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_pos      <= 5'd0;
         r_len      <= 16'h0000;
         r_crc      <= 32'h0;
         r_len_type <= 16'h0000;
         r_pre_err  <= 1'b0;
         r_hdr_err  <= 1'b0;
         r_len_err  <= 1'b0;
         r_done     <= 1'b0;
         r_pre_o    <= 1'b0;
         r_hdr_o    <= 1'b0;
         r_pay_o    <= 1'b0;
         r_fcs_o    <= 1'b0;
         r_len_o    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_valid) begin
            r_state    <= w_state;
            r_pos      <= w_pos;
            r_len      <= w_len;
            r_crc      <= w_crc;
            r_len_type <= w_len_type;
            r_pre_err  <= w_pre_err;
            r_hdr_err  <= w_hdr_err;
            r_len_err  <= w_len_err;
            if (w_close) begin
               r_done  <= 1'b1;
               r_pre_o <= w_pre_err;
               r_hdr_o <= w_hdr_err;
               r_pay_o <= w_pay_bad;
               r_fcs_o <= w_fcs_bad;
               r_len_o <= w_len_bad;
            end
         end
      end
   end

`ifdef MAC_CHECKER_STATS_EN
   logic [31:0] r_frame_cnt, r_error_cnt;
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_frame_cnt <= 32'h0;
         r_error_cnt <= 32'h0;
      end else if (i_valid && w_close) begin
         r_frame_cnt <= r_frame_cnt + 32'd1;
         if (w_any_err)
            r_error_cnt <= r_error_cnt + 32'd1;
      end
   end
   assign o_frame_count = r_frame_cnt;
   assign o_error_count = r_error_cnt;
`else
   assign o_frame_count = 32'h0;
   assign o_error_count = 32'h0;
`endif

   assign o_frame_done     = r_done;
   assign o_preamble_error = r_pre_o;
   assign o_header_error   = r_hdr_o;
   assign o_payload_error  = r_pay_o;
   assign o_fcs_error      = r_fcs_o;
   assign o_length_error   = r_len_o;

endmodule

// File: tb/tb_mac_stream_checker.sv
`timescale 1ns/1ps
module tb_mac_stream_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] d64 = '0;
   logic [7:0]  c64 = '0;
   logic        v64 = 1'b0;
   logic [31:0] d32 = '0;
   logic [3:0]  c32 = '0;
   logic        v32 = 1'b0;

   logic        done64, pre64, hdr64, pay64, fcs64, len64;
   logic [31:0] fcnt64, ecnt64;
   logic        done32, pre32, hdr32, pay32, fcs32, len32;
   logic [31:0] fcnt32, ecnt32;

   int n_checks = 0;
   int n_errors = 0;

   // Expected flags {pre, hdr, pay, fcs, len}, one entry per frame that must close.
   logic [4:0] q64[$];
   logic [4:0] q32[$];
   int exp_f64 = 0, exp_e64 = 0, exp_f32 = 0, exp_e32 = 0;

   // Byte stream under construction: bit 8 is the control flag.
   logic [8:0] sq[$];

   always #5 clk = ~clk;

   mac_stream_checker #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) u_dut64 (
      .clk(clk), .i_rst_n(rst_n), .i_rx_data(d64), .i_rx_ctrl(c64), .i_valid(v64),
      .o_frame_done(done64), .o_preamble_error(pre64), .o_header_error(hdr64),
      .o_payload_error(pay64), .o_fcs_error(fcs64), .o_length_error(len64),
      .o_frame_count(fcnt64), .o_error_count(ecnt64));

   mac_stream_checker #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) u_dut32 (
      .clk(clk), .i_rst_n(rst_n), .i_rx_data(d32), .i_rx_ctrl(c32), .i_valid(v32),
      .o_frame_done(done32), .o_preamble_error(pre32), .o_header_error(hdr32),
      .o_payload_error(pay32), .o_fcs_error(fcs32), .o_length_error(len32),
      .o_frame_count(fcnt32), .o_error_count(ecnt32));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] x;
      x = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
      return x;
   endfunction

   // Appends START, preamble, DA..FCS, TERM, then IDLE padding to an 8-byte boundary.
   task automatic add_frame(input logic [15:0] lt, input int plen, input int flip,
                            input int pre_bad, input logic [47:0] sa, input int idle_at);
      logic [7:0]  fb[$];
      logic [31:0] crc;
      logic [47:0] da;
      da = 48'hFFFFFFFFFFFF;
      for (int i = 5; i >= 0; i--) fb.push_back(da[8*i +: 8]);
      for (int i = 5; i >= 0; i--) fb.push_back(sa[8*i +: 8]);
      fb.push_back(lt[15:8]);
      fb.push_back(lt[7:0]);
      for (int i = 0; i < plen; i++) fb.push_back(8'(i));
      crc = 32'hFFFFFFFF;
      foreach (fb[i]) crc = crc_upd(crc, fb[i]);
      crc = ~crc;
      for (int i = 0; i < 4; i++) fb.push_back(crc[8*i +: 8]);
      if (flip >= 0) fb[14 + flip] = fb[14 + flip] ^ 8'h01;
      sq.push_back({1'b1, 8'hFB});
      for (int p = 1; p <= 6; p++) sq.push_back({1'b0, (p == pre_bad) ? 8'h54 : 8'h55});
      sq.push_back({1'b0, 8'hD5});
      foreach (fb[i]) begin
         if (idle_at >= 0 && i == 14 + idle_at) sq.push_back({1'b1, 8'h07});
         else sq.push_back({1'b0, fb[i]});
      end
      sq.push_back({1'b1, 8'hFD});
      while (sq.size() % 8 != 0) sq.push_back({1'b1, 8'h07});
   endtask

   // Drives the stream to one DUT; optional 3-cycle valid gap before word gap_w,
   // optional early stop before word stop_w (frame abandoned).
   task automatic drive(input int sel, input int gap_w, input int stop_w);
      int bpw, nw;
      logic [8:0] e;
      bpw = (sel == 0) ? 8 : 4;
      nw  = sq.size() / bpw;
      for (int w = 0; w < nw; w++) begin
         if (w == stop_w) break;
         if (w == gap_w) begin
            repeat (3) begin
               @(negedge clk);
               v64 = 1'b0;
               v32 = 1'b0;
            end
         end
         @(negedge clk);
         for (int b = 0; b < bpw; b++) begin
            e = sq[w*bpw + b];
            if (sel == 0) begin
               d64[8*b +: 8] = e[7:0];
               c64[b] = e[8];
            end else begin
               d32[8*b +: 8] = e[7:0];
               c32[b] = e[8];
            end
         end
         if (sel == 0) v64 = 1'b1; else v32 = 1'b1;
      end
      @(negedge clk);
      v64 = 1'b0;
      v32 = 1'b0;
      sq.delete();
   endtask

   task automatic run64(input logic [4:0] f);
      q64.push_back(f);
      drive(0, -1, -1);
   endtask

   // Scoreboard for the 64-bit DUT.
   always @(negedge clk) begin
      logic [4:0] e;
      if (!rst_n) begin
         exp_f64 = 0;
         exp_e64 = 0;
      end else if (done64) begin
         if (q64.size() == 0) begin
            chk("spurious_done64", 32'(done64), 32'd0);
         end else begin
            e = q64.pop_front();
            exp_f64++;
            if (e != 5'b0) exp_e64++;
            chk("flags64", {27'd0, pre64, hdr64, pay64, fcs64, len64}, {27'd0, e});
`ifdef MAC_CHECKER_STATS_EN
            chk("fcnt64", fcnt64, 32'(exp_f64));
            chk("ecnt64", ecnt64, 32'(exp_e64));
`else
            chk("fcnt64", fcnt64, 32'd0);
            chk("ecnt64", ecnt64, 32'd0);
`endif
         end
      end
   end

   // Scoreboard for the 32-bit DUT.
   always @(negedge clk) begin
      logic [4:0] e;
      if (!rst_n) begin
         exp_f32 = 0;
         exp_e32 = 0;
      end else if (done32) begin
         if (q32.size() == 0) begin
            chk("spurious_done32", 32'(done32), 32'd0);
         end else begin
            e = q32.pop_front();
            exp_f32++;
            if (e != 5'b0) exp_e32++;
            chk("flags32", {27'd0, pre32, hdr32, pay32, fcs32, len32}, {27'd0, e});
`ifdef MAC_CHECKER_STATS_EN
            chk("fcnt32", fcnt32, 32'(exp_f32));
            chk("ecnt32", ecnt32, 32'(exp_e32));
`else
            chk("fcnt32", fcnt32, 32'd0);
            chk("ecnt32", ecnt32, 32'd0);
`endif
         end
      end
   end

   localparam logic [47:0] SA_OK  = 48'h123456789ABC;
   localparam logic [47:0] SA_BAD = 48'h123456789ABD;

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_done64", 32'(done64), 32'd0);
      chk("rst_flags64", {27'd0, pre64, hdr64, pay64, fcs64, len64}, 32'd0);
      chk("rst_fcnt64", fcnt64, 32'd0);
      chk("rst_ecnt64", ecnt64, 32'd0);
      chk("rst_done32", 32'(done32), 32'd0);
      chk("rst_flags32", {27'd0, pre32, hdr32, pay32, fcs32, len32}, 32'd0);
      chk("rst_fcnt32", fcnt32, 32'd0);
      chk("rst_ecnt32", ecnt32, 32'd0);

      add_frame(16'h002E, 46, -1, 0, SA_OK, -1);   run64(5'b00000); // clean 64-byte frame
      add_frame(16'h002E, 46, 10, 0, SA_OK, -1);   run64(5'b00010); // payload bit flip
      add_frame(16'h0030, 46, -1, 0, SA_OK, -1);   run64(5'b00100); // length field 48
      add_frame(16'h002E, 46, -1, 3, SA_OK, -1);   run64(5'b10000); // preamble 0x54
      add_frame(16'h002E, 46, -1, 0, SA_BAD, -1);  run64(5'b01000); // wrong SA
      add_frame(16'h0800, 1500, -1, 0, SA_OK, -1); run64(5'b00000); // L = 1518
      add_frame(16'h0800, 1501, -1, 0, SA_OK, -1); run64(5'b00001); // L = 1519
      add_frame(16'h0800, 22, -1, 0, SA_OK, -1);   run64(5'b00001); // L = 40

      // Valid gap inside the payload of a frame that completes.
      add_frame(16'h002E, 46, -1, 0, SA_OK, -1);
      q64.push_back(5'b00000);
      drive(0, 5, -1);

      // Abandoned frame: gap, then reset mid-frame; no done pulse is expected.
      add_frame(16'h002E, 46, -1, 0, SA_OK, -1);
      drive(0, 5, 7);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_fcnt64", fcnt64, 32'd0);
      add_frame(16'h002E, 46, -1, 0, SA_OK, -1);   run64(5'b00000);

      // 49-byte payload: TERM lands in lane 3 on both widths.
      add_frame(16'h0031, 49, -1, 0, SA_OK, -1);   run64(5'b00000);
      add_frame(16'h0031, 49, -1, 0, SA_OK, -1);
      q32.push_back(5'b00000);
      drive(1, -1, -1);

      // Back-to-back: IDLE inside frame 1 payload forces DRAIN; frame 2 follows immediately.
      add_frame(16'h002E, 46, -1, 0, SA_OK, 20);
      add_frame(16'h002E, 46, -1, 0, SA_OK, -1);
      q64.push_back(5'b00111);
      q64.push_back(5'b00000);
      drive(0, -1, -1);

      repeat (5) @(negedge clk);
      chk("pending64", 32'(q64.size()), 32'd0);
      chk("pending32", 32'(q32.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
